// File: rtl/regfile_wb_if.sv
// Read-stage / write-back bundle for the register file.
// The read stage drives the master side and regfile_wb implements the slave side.
interface regfile_wb_if #(
    parameter int D_W = 16,
    parameter int A_W = 3
);
    logic [A_W-1:0] src1;
    logic [A_W-1:0] src2;
    logic [D_W-1:0] op1;
    logic [D_W-1:0] op2;
    logic           haz1;
    logic           haz2;
    logic           iss_valid;
    logic [A_W-1:0] iss_dst;
    logic           iss_ready;
    logic           wb_valid;
    logic [A_W-1:0] wb_dst;
    logic [D_W-1:0] wb_data;
    logic           sb_err;

    modport slave (
        input  src1, src2, iss_valid, iss_dst,
        input  wb_valid, wb_dst, wb_data,
        output op1, op2, haz1, haz2, iss_ready, sb_err
    );

    modport master (
        output src1, src2, iss_valid, iss_dst,
        output wb_valid, wb_dst, wb_data,
        input  op1, op2, haz1, haz2, iss_ready, sb_err
    );
endinterface

// File: rtl/regfile_wb.sv
// Register file with write-through bypass and a per-register
// scoreboard of in-flight writes for RAW hazard detection.
module regfile_wb #(
    parameter int D_W   = 16,
    parameter int NREGS = 8,
    parameter int A_W   = 3,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_wb_if.slave  rf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [D_W-1:0]   regs_q [NREGS];
    logic [D_W-1:0]   regs_d [NREGS];
    logic [CNT_W-1:0] cnt_q  [NREGS];
    logic [CNT_W-1:0] cnt_d  [NREGS];
    logic             sb_err_q;
    logic             sb_err_d;

    logic [CNT_W-1:0] cnt_s1;
    logic [CNT_W-1:0] cnt_s2;
    logic [CNT_W-1:0] cnt_iss;
    logic [CNT_W-1:0] cnt_wb;
    logic             hit1;
    logic             hit2;
    logic             hit_iss;
    logic             iss_ready;
    logic             iss_fire;
    logic             wb_dec;
    logic             inc_r;
    logic             dec_r;

    always_comb begin
        cnt_s1  = cnt_q[rf.src1];
        cnt_s2  = cnt_q[rf.src2];
        cnt_iss = cnt_q[rf.iss_dst];
        cnt_wb  = cnt_q[rf.wb_dst];

        hit1    = rf.wb_valid && (rf.wb_dst == rf.src1);
        hit2    = rf.wb_valid && (rf.wb_dst == rf.src2);
        hit_iss = rf.wb_valid && (rf.wb_dst == rf.iss_dst);

        // A write-back landing this cycle frees a slot for issue.
        iss_ready = !((cnt_iss == CNT_MAX) &&
                      !(hit_iss && (cnt_iss != '0)));
        iss_fire  = rf.iss_valid && iss_ready;
        wb_dec    = rf.wb_valid && (cnt_wb != '0);
        sb_err_d  = sb_err_q || (rf.wb_valid && (cnt_wb == '0));

        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            inc_r     = iss_fire && (rf.iss_dst == A_W'(r));
            dec_r     = wb_dec && (rf.wb_dst == A_W'(r));
            if (rf.wb_valid && (rf.wb_dst == A_W'(r))) begin
                regs_d[r] = rf.wb_data;
            end
            case ({inc_r, dec_r})
                2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
                2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    assign rf.op1       = hit1 ? rf.wb_data : regs_q[rf.src1];
    assign rf.op2       = hit2 ? rf.wb_data : regs_q[rf.src2];
    // Last outstanding write landing now is bypassed, not a hazard.
    assign rf.haz1      = (cnt_s1 != '0) && !(hit1 && (cnt_s1 == CNT_ONE));
    assign rf.haz2      = (cnt_s2 != '0) && !(hit2 && (cnt_s2 == CNT_ONE));
    assign rf.iss_ready = iss_ready;
    assign rf.sb_err    = sb_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vectors with literal checks
// plus a per-cycle comparison against a behavioural model.
module tb_regfile_wb;
    logic clk;
    logic rst_n;
    bit   started;
    int   n_chk;
    int   n_fail;

    int   m_regs [8];
    int   m_cnt  [8];
    bit   m_err;

    regfile_wb_if #(.D_W(16), .A_W(3)) rf ();

    regfile_wb #(
        .D_W(16), .NREGS(8), .A_W(3), .CNT_W(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic int landing(input int d);
        return (rf.wb_valid && int'(rf.wb_dst) == d && m_cnt[d] > 0) ? 1 : 0;
    endfunction

    // Issue allowed if, after this cycle's landing, fewer than 3 are in flight.
    function automatic bit m_ready(input int d);
        return (m_cnt[d] - landing(d)) < 3;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 8; r++) begin
                m_regs[r] = 0;
                m_cnt[r]  = 0;
            end
            m_err = 1'b0;
        end else begin
            bit fire;
            int land;
            fire = rf.iss_valid && m_ready(int'(rf.iss_dst));
            land = rf.wb_valid ? landing(int'(rf.wb_dst)) : 0;
            if (rf.wb_valid) begin
                if (land == 0) m_err = 1'b1;
                m_regs[rf.wb_dst] = int'(rf.wb_data);
                m_cnt[rf.wb_dst]  = m_cnt[rf.wb_dst] - land;
            end
            if (fire) m_cnt[rf.iss_dst] = m_cnt[rf.iss_dst] + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int s1, s2, e1, e2;
            s1 = int'(rf.src1);
            s2 = int'(rf.src2);
            e1 = (rf.wb_valid && int'(rf.wb_dst) == s1) ? int'(rf.wb_data) : m_regs[s1];
            e2 = (rf.wb_valid && int'(rf.wb_dst) == s2) ? int'(rf.wb_data) : m_regs[s2];
            chk("cmp_op1", 32'(rf.op1), 32'(e1));
            chk("cmp_op2", 32'(rf.op2), 32'(e2));
            chk("cmp_haz1", 32'(rf.haz1), 32'((m_cnt[s1] - landing(s1)) > 0));
            chk("cmp_haz2", 32'(rf.haz2), 32'((m_cnt[s2] - landing(s2)) > 0));
            chk("cmp_ready", 32'(rf.iss_ready), 32'(m_ready(int'(rf.iss_dst))));
            chk("cmp_sb_err", 32'(rf.sb_err), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.iss_valid = 1'b0;
        rf.wb_valid  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        started = 1'b0;
        rst_n = 1'b0;
        rf.src1 = '0;
        rf.src2 = '0;
        rf.iss_dst = '0;
        rf.wb_dst = '0;
        rf.wb_data = '0;
        idle();
        step();
        started = 1'b1;
        step();
        rst_n = 1'b1;

        // 1: reset state of every register
        for (int i = 0; i < 8; i++) begin
            rf.src1 = 3'(i);
            rf.src2 = 3'(7 - i);
            rf.iss_dst = 3'(i);
            #1;
            chk("rst_op1", 32'(rf.op1), 32'h0);
            chk("rst_op2", 32'(rf.op2), 32'h0);
            chk("rst_haz", 32'({rf.haz1, rf.haz2}), 32'h0);
            chk("rst_ready", 32'(rf.iss_ready), 32'h1);
            chk("rst_sb_err", 32'(rf.sb_err), 32'h0);
            step();
        end

        // 2: bypass then registered read
        rf.wb_valid = 1'b1;
        rf.wb_dst = 3'd3;
        rf.wb_data = 16'hBEEF;
        rf.src1 = 3'd3;
        #1;
        chk("byp_op1", 32'(rf.op1), 32'hBEEF);
        step();
        idle();
        #1;
        chk("reg_op1", 32'(rf.op1), 32'hBEEF);
        chk("err_r3", 32'(rf.sb_err), 32'h1);
        step();
        do_reset();
        #1;
        chk("err_clr", 32'(rf.sb_err), 32'h0);
        chk("r3_clr", 32'(rf.op1), 32'h0);

        // 3: single RAW hazard resolved by write-back
        rf.iss_valid = 1'b1;
        rf.iss_dst = 3'd5;
        step();
        idle();
        rf.src2 = 3'd5;
        #1;
        chk("haz2_set", 32'(rf.haz2), 32'h1);
        step();
        rf.wb_valid = 1'b1;
        rf.wb_dst = 3'd5;
        rf.wb_data = 16'h0042;
        #1;
        chk("haz2_land", 32'(rf.haz2), 32'h0);
        chk("op2_land", 32'(rf.op2), 32'h0042);
        step();
        idle();
        #1;
        chk("haz2_after", 32'(rf.haz2), 32'h0);
        chk("op2_after", 32'(rf.op2), 32'h0042);
        chk("err_r5", 32'(rf.sb_err), 32'h0);

        // 4: saturation of r2 and same-cycle slot release
        rf.iss_valid = 1'b1;
        rf.iss_dst = 3'd2;
        rf.src1 = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sat_ready", 32'(rf.iss_ready), 32'h1);
            step();
        end
        #1;
        chk("sat_block", 32'(rf.iss_ready), 32'h0);
        chk("sat_haz1", 32'(rf.haz1), 32'h1);
        step();
        rf.wb_valid = 1'b1;
        rf.wb_dst = 3'd2;
        rf.wb_data = 16'h2222;
        #1;
        chk("sat_free", 32'(rf.iss_ready), 32'h1);
        chk("sat_haz_wb", 32'(rf.haz1), 32'h1);
        step();
        rf.wb_valid = 1'b0;
        #1;
        chk("sat_still3", 32'(rf.iss_ready), 32'h0);
        rf.iss_valid = 1'b0;
        rf.wb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rf.wb_data = 16'(16'h2300 + i);
            step();
        end
        idle();
        #1;
        chk("drain_haz1", 32'(rf.haz1), 32'h0);
        chk("drain_op1", 32'(rf.op1), 32'h2302);
        chk("drain_err", 32'(rf.sb_err), 32'h0);

        // 5: write-back with nothing pending
        rf.wb_valid = 1'b1;
        rf.wb_dst = 3'd7;
        rf.wb_data = 16'h7777;
        step();
        idle();
        rf.src1 = 3'd7;
        #1;
        chk("err_set", 32'(rf.sb_err), 32'h1);
        chk("r7_data", 32'(rf.op1), 32'h7777);
        step();
        chk("err_hold", 32'(rf.sb_err), 32'h1);
        do_reset();
        #1;
        chk("err_rst", 32'(rf.sb_err), 32'h0);

        // 6: reset beats concurrent issue and write-back
        rf.iss_valid = 1'b1;
        rf.iss_dst = 3'd1;
        rf.wb_valid = 1'b1;
        rf.wb_dst = 3'd1;
        rf.wb_data = 16'h1111;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        rf.src1 = 3'd1;
        #1;
        chk("rw_op1", 32'(rf.op1), 32'h0);
        chk("rw_haz1", 32'(rf.haz1), 32'h0);

        // Mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 80; i++) begin
            rf.src1 = 3'($urandom_range(7));
            rf.src2 = (i % 5 == 0) ? rf.src1 : 3'($urandom_range(7));
            rf.iss_valid = ($urandom_range(2) != 0);
            rf.iss_dst = 3'($urandom_range(3));
            rf.wb_valid = ($urandom_range(2) == 0);
            rf.wb_dst = 3'($urandom_range(3));
            rf.wb_data = 16'($urandom);
            rst_n = (i != 50);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
